// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings and defaults for the two-requester round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/mux2.sv
// Datapath 2:1 multiplexer: sel=1 passes d1, sel=0 passes d0.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational two-way round-robin picker; the side that did not win last gets a tie.
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_grant,
  output logic pick
);

  assign pick = (a_valid && (!b_valid || last_grant == SEL_B)) ? SEL_A : SEL_B;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 2:1 datapath mux with a one-entry output register.
// Optional ARB_LOCK_EN adds lock_a/lock_b to pin ownership past the burst limit.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ARB_LOCK_EN
  input  logic             lock_a,
  input  logic             lock_b,
`endif
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             mux_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int CNT_W = 8;

  arb_state_e        state_q, state_d, oth_state;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              sel_q;
  logic              own_a, own_b, slot_free, acc;
  logic              own_v, oth_v, lock_own, pick;
  logic [WIDTH-1:0]  mux_y;

  assign own_a     = (state_q == OWN_A);
  assign own_b     = (state_q == OWN_B);
  assign slot_free = !out_valid || out_ready;
  assign a_ready   = own_a && slot_free;
  assign b_ready   = own_b && slot_free;
  assign acc       = (a_ready && a_valid) || (b_ready && b_valid);
  assign own_v     = own_a ? a_valid : b_valid;
  assign oth_v     = own_a ? b_valid : a_valid;
  assign oth_state = own_a ? OWN_B : OWN_A;

  // Idle keeps the previous select so the shared mux does not toggle needlessly.
  assign mux_sel = own_a ? SEL_A : (own_b ? SEL_B : sel_q);

`ifdef ARB_LOCK_EN
  assign lock_own = own_a ? lock_a : (own_b ? lock_b : 1'b0);
`else
  assign lock_own = 1'b0;
`endif

  rr_pick u_pick (
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_q),
    .pick       (pick)
  );

  mux2 #(.WIDTH(WIDTH)) u_mux (
    .sel (mux_sel),
    .d1  (a_data),
    .d0  (b_data),
    .y   (mux_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (a_valid || b_valid) state_d = (pick == SEL_A) ? OWN_A : OWN_B;
      end
      OWN_A, OWN_B: begin
        // Nothing moves while the output register is blocked.
        if (slot_free) begin
          if (own_v) begin
            last_d = own_a ? SEL_A : SEL_B;
            if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
              // A locked owner parks at the limit so the first unlocked beat hands over.
              if (!lock_own) begin
                cnt_d = '0;
                if (oth_v) state_d = oth_state;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (!lock_own) begin
            cnt_d   = '0;
            state_d = oth_v ? oth_state : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_B;
      sel_q     <= SEL_B;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= mux_sel;
      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= mux_y;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized bench for mux_rr_arbiter: transaction-level ownership model plus output scoreboard.
module tb_mux_rr_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a_valid = 1'b0, b_valid = 1'b0;
  logic [WIDTH-1:0] a_data = '0, b_data = '0;
  logic             a_ready, b_ready, mux_sel, out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .mux_sel   (mux_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model: owner 0=none 1=A 2=B; run = beats taken in the current tenure.
  int               mown, mlast, run;
  bit               mov, msel, acc_a, acc_b;
  logic [WIDTH-1:0] mdata;
  logic [WIDTH-1:0] sb[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mown = 0; mlast = 2; run = 0; mov = 0; msel = 0;
      mdata = '0; acc_a = 0; acc_b = 0;
      sb.delete();
    end else begin
      bit ra, rb, myv, otv, r;
      logic [WIDTH-1:0] d;
      ra = (mown == 1) && (!mov || out_ready);
      rb = (mown == 2) && (!mov || out_ready);
      chk("a_ready", a_ready, ra);
      chk("b_ready", b_ready, rb);
      chk("mux_sel", mux_sel, msel);
      chk("out_valid", out_valid, mov);
      chk("out_data", out_data, mdata);
      acc_a = ra && a_valid;
      acc_b = rb && b_valid;
      if (mown == 0) begin
        if (a_valid && b_valid) mown = (mlast == 1) ? 2 : 1;
        else if (a_valid)       mown = 1;
        else if (b_valid)       mown = 2;
        run = 0;
      end else begin
        myv = (mown == 1) ? a_valid : b_valid;
        otv = (mown == 1) ? b_valid : a_valid;
        r   = (mown == 1) ? ra : rb;
        d   = (mown == 1) ? a_data : b_data;
        if (r && myv) begin
          sb.push_back(d);
          mdata = d;
          mlast = mown;
          run++;
          if (run == MAX_HOLD) begin
            run = 0;
            if (otv) mown = 3 - mown;
          end
        end else if (r) begin
          run  = 0;
          mown = otv ? 3 - mown : 0;
        end
      end
      if (acc_a || acc_b) mov = 1;
      else if (out_ready) mov = 0;
      if (mown != 0) msel = (mown == 1);
    end
  end

  // Scoreboard monitor: every drained beat must be the oldest accepted one.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else chk("sb_data", out_data, sb.pop_front());
    end
  end

  int a_seq = 1, b_seq = 0;

  task automatic step(input int pa, input int pb, input int pr, input bit rnd);
    @(posedge clk); #1;
    if (!a_valid || acc_a) begin
      a_valid = ($urandom_range(99) < pa);
      if (a_valid) begin
        a_data = rnd ? WIDTH'($urandom) : WIDTH'(a_seq * 8'h11);
        a_seq++;
      end
    end
    if (!b_valid || acc_b) begin
      b_valid = ($urandom_range(99) < pb);
      if (b_valid) begin
        b_data = rnd ? WIDTH'($urandom) : WIDTH'(8'h80 + b_seq);
        b_seq++;
      end
    end
    out_ready = ($urandom_range(99) < pr);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pa, pb, pr;
    do_reset();
    // A alone: bubble, then 0x11,0x22,0x33 back to back.
    repeat (4) step(100, 0, 100, 0);
    repeat (4) step(0, 0, 100, 0);
    // Both requesting from reset: A first, bursts of MAX_HOLD alternate.
    do_reset();
    repeat (20) step(100, 100, 100, 0);
    // Downstream stall with a full output register.
    repeat (3) step(100, 100, 0, 0);
    repeat (4) step(100, 100, 100, 0);
    // Owner goes quiet while the other side waits, then everyone goes quiet.
    repeat (6) step(0, 100, 100, 0);
    repeat (4) step(0, 0, 100, 0);
    repeat (3) step(100, 0, 100, 0);
    // Reset with a beat held in the output register.
    repeat (2) step(100, 0, 0, 1);
    do_reset();
    repeat (3) step(0, 0, 100, 1);
    // Randomized traffic with shifting pressure.
    for (int k = 0; k < 20; k++) begin
      pa = $urandom_range(100);
      pb = $urandom_range(100);
      pr = $urandom_range(20, 100);
      repeat (150) step(pa, pb, pr, 1);
      if (k == 10) do_reset();
    end
    repeat (4) step(0, 0, 100, 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
